// File: rtl/btn_event_arbiter.sv
// Button event arbiter: classifies each debounced press as SHORT or LONG,
// keeps one pending event per button and serializes the pending events onto
// a single output port using round-robin arbitration.
//
// Handshake: evt_valid/evt_id/evt_long form a registered output. An event
// transfers on a rising edge where evt_valid=1 and evt_ready=1. While
// evt_valid=1 and evt_ready=0 the id and type are held constant. The output
// register may reload on the same edge as a transfer, so sustained
// throughput is one event per cycle.
module btn_event_arbiter #(
  parameter int N_BTN      = 4,
  parameter int LONG_TICKS = 3000,
  parameter int ID_W       = $clog2(N_BTN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_lvl,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_long,
  output logic               evt_ovf,
  output logic [2*N_BTN-1:0] dbg_state
);

  localparam int CNT_W = $clog2(LONG_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HELD    = 2'd1,
    S_LATCHED = 2'd2
  } state_t;

  // Per-button state
  state_t             r_state [N_BTN];
  logic [CNT_W-1:0]   r_cnt   [N_BTN];
  logic [N_BTN-1:0]   r_prev;
  logic [N_BTN-1:0]   r_pend;
  logic [N_BTN-1:0]   r_type;

  // Output register and arbitration pointer
  logic               r_evt_valid;
  logic [ID_W-1:0]    r_evt_id;
  logic               r_evt_long;
  logic               r_evt_ovf;
  logic [ID_W-1:0]    r_rr_ptr;

  // Next-state / combinational results
  state_t             w_state_nxt [N_BTN];
  logic [CNT_W-1:0]   w_cnt_nxt   [N_BTN];
  logic [N_BTN-1:0]   w_raise;
  logic [N_BTN-1:0]   w_raise_long;

  logic               w_free;
  logic               w_grant_vld;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_load;
  logic [2*N_BTN-1:0] w_dbl;
  logic [N_BTN-1:0]   w_rot;
  logic [ID_W:0]      w_sum;

  logic [N_BTN-1:0]   w_clr;
  logic [N_BTN-1:0]   w_pend_nxt;
  logic [N_BTN-1:0]   w_type_nxt;
  logic               w_drop;

  // Per-button press classifier: next state, hold counter and event raise
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i]  = r_state[i];
      w_cnt_nxt[i]    = r_cnt[i];
      w_raise[i]      = 1'b0;
      w_raise_long[i] = 1'b0;
      case (r_state[i])
        S_IDLE: begin
          // Only a fresh rising edge starts a press; a button held through
          // reset sees prev=1 and is ignored until released.
          if (btn_lvl[i] && !r_prev[i]) begin
            w_state_nxt[i] = S_HELD;
            w_cnt_nxt[i]   = CNT_W'(1);
          end
        end
        S_HELD: begin
          if (btn_lvl[i]) begin
            if (r_cnt[i] == CNT_W'(LONG_TICKS - 1)) begin
              w_raise[i]      = 1'b1;
              w_raise_long[i] = 1'b1;
              w_state_nxt[i]  = S_LATCHED;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
          end else begin
            w_raise[i]     = 1'b1;
            w_state_nxt[i] = S_IDLE;
          end
        end
        S_LATCHED: begin
          // Release after a LONG press is silent
          if (!btn_lvl[i]) begin
            w_state_nxt[i] = S_IDLE;
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
        end
      endcase
    end
  end

  // Round-robin grant: first pending slot at or after r_rr_ptr
  always_comb begin
    w_free      = !r_evt_valid || evt_ready;
    w_dbl       = {r_pend, r_pend} >> r_rr_ptr;
    w_rot       = w_dbl[N_BTN-1:0];
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = 0; k < N_BTN; k++) begin
      if (!w_grant_vld && w_rot[k]) begin
        w_grant_vld = 1'b1;
        w_sum       = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
        if (w_sum >= (ID_W + 1)'(N_BTN)) begin
          w_sum = w_sum - (ID_W + 1)'(N_BTN);
        end
        w_grant_idx = w_sum[ID_W-1:0];
      end
    end
    w_load = w_free && w_grant_vld;
  end

  // Pending slot update: a granted slot frees up on the same edge, so a new
  // event arriving then is kept rather than counted as an overflow.
  always_comb begin
    w_drop = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      w_clr[i]      = w_load && (w_grant_idx == ID_W'(i));
      w_pend_nxt[i] = r_pend[i] && !w_clr[i];
      w_type_nxt[i] = r_type[i];
      if (w_raise[i]) begin
        if (!r_pend[i] || w_clr[i]) begin
          w_pend_nxt[i] = 1'b1;
          w_type_nxt[i] = w_raise_long[i];
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  // Per-button state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= '0;
      end
      r_prev <= '1;
      r_pend <= '0;
      r_type <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_prev <= btn_lvl;
      r_pend <= w_pend_nxt;
      r_type <= w_type_nxt;
    end
  end

  // Output register, round-robin pointer and sticky overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_long  <= 1'b0;
      r_evt_ovf   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_drop) begin
        r_evt_ovf <= 1'b1;
      end
      if (w_free) begin
        if (w_grant_vld) begin
          r_evt_valid <= 1'b1;
          r_evt_id    <= w_grant_idx;
          r_evt_long  <= r_type[w_grant_idx];
          r_rr_ptr    <= (w_grant_idx == ID_W'(N_BTN - 1)) ? '0
                                                           : w_grant_idx + ID_W'(1);
        end else begin
          r_evt_valid <= 1'b0;
        end
      end
    end
  end

  // Debug view of every button FSM, two bits per button
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      dbg_state[2*i +: 2] = r_state[i];
    end
  end

  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_long  = r_evt_long;
  assign evt_ovf   = r_evt_ovf;

endmodule
